// File: rtl/seq_det_sched.sv
// Arbitrates NREQ requesters, serialises the granted word MSB first into a "110" Mealy
// detector and reports the match count. Define SEQ_DET_SCHED_FIXED_PRIO_EN for fixed priority.
module seq_det_sched #(
   parameter int NREQ   = 4,
   parameter int WORD_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WORD_W-1:0] data,
   output logic [NREQ-1:0]        gnt,
   output logic                   busy,
   output logic                   ser_x,
   output logic                   done,
   output logic [1:0]             done_id,
   output logic [3:0]             match_cnt
);
   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
   typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2} det_t;

   state_t            state_r;
   det_t              det_r;
   det_t              det_nxt_s;
   logic              match_s;
   logic [1:0]        win_r;
   logic [1:0]        win_s;
   logic              win_vld_s;
   logic [1:0]        idx_s;
   logic [WORD_W-1:0] data_word_s;
   logic [WORD_W-1:0] shreg_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [3:0]        mcnt_r;
   logic [3:0]        mcnt_nxt_s;
   logic [NREQ-1:0]   gnt_r;
   logic              busy_r;
   logic              ser_x_r;
   logic              done_r;
   logic [1:0]        done_id_r;
   logic [3:0]        match_cnt_r;
`ifndef SEQ_DET_SCHED_FIXED_PRIO_EN
   logic [1:0]        ptr_r;
`endif

   function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic inc);
      if (inc && (cnt != 4'hF)) begin
         return cnt + 4'd1;
      end else begin
         return cnt;
      end
   endfunction

   assign data_word_s = data[32'(win_r) * WORD_W +: WORD_W];

   // Arbiter: scan from highest to lowest priority offset so the highest-priority request wins last
   always_comb begin
      win_s     = 2'd0;
      win_vld_s = 1'b0;
      idx_s     = 2'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
         idx_s = 2'(k);
`else
         idx_s = ptr_r + 2'(k);
`endif
         win_s     = req[idx_s] ? idx_s : win_s;
         win_vld_s = win_vld_s | req[idx_s];
      end
   end

   // Mealy "110" detector; a trailing 0 that completes a match is not reused
   always_comb begin
      det_nxt_s = D0;
      match_s   = 1'b0;
      case (det_r)
         D0: det_nxt_s = ser_x_r ? D1 : D0;
         D1: det_nxt_s = ser_x_r ? D2 : D0;
         D2: begin
            det_nxt_s = ser_x_r ? D2 : D0;
            match_s   = ~ser_x_r;
         end
         default: det_nxt_s = D0;
      endcase
      mcnt_nxt_s = sat_inc(mcnt_r, match_s);
   end

   // Control FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r     <= IDLE;
         det_r       <= D0;
         win_r       <= 2'd0;
         shreg_r     <= '0;
         bit_cnt_r   <= '0;
         mcnt_r      <= 4'd0;
         gnt_r       <= '0;
         busy_r      <= 1'b0;
         ser_x_r     <= 1'b0;
         done_r      <= 1'b0;
         done_id_r   <= 2'd0;
         match_cnt_r <= 4'd0;
`ifndef SEQ_DET_SCHED_FIXED_PRIO_EN
         ptr_r       <= 2'd0;
`endif
      end else begin
         gnt_r  <= '0;
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (win_vld_s) begin
                  state_r <= LOAD;
                  win_r   <= win_s;
                  gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                  busy_r  <= 1'b1;
`ifndef SEQ_DET_SCHED_FIXED_PRIO_EN
                  ptr_r   <= win_s + 2'd1;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD: begin
               shreg_r   <= data_word_s << 1;
               ser_x_r   <= data_word_s[WORD_W-1];
               bit_cnt_r <= '0;
               mcnt_r    <= 4'd0;
               det_r     <= D0;
               state_r   <= SHIFT;
            end
            SHIFT: begin
               det_r  <= det_nxt_s;
               mcnt_r <= mcnt_nxt_s;
               if (bit_cnt_r == LAST_BIT) begin
                  ser_x_r     <= 1'b0;
                  done_r      <= 1'b1;
                  done_id_r   <= win_r;
                  match_cnt_r <= mcnt_nxt_s;
                  state_r     <= DONE;
               end else begin
                  ser_x_r   <= shreg_r[WORD_W-1];
                  shreg_r   <= shreg_r << 1;
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               ser_x_r <= 1'b0;
               det_r   <= D0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_r;
   assign busy      = busy_r;
   assign ser_x     = ser_x_r;
   assign done      = done_r;
   assign done_id   = done_id_r;
   assign match_cnt = match_cnt_r;
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed, scoreboard-based bench for seq_det_sched (both arbitration builds).
module tb_seq_det_sched;
   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [31:0] data = 32'h0;
   logic [3:0]  gnt;
   logic        busy;
   logic        ser_x;
   logic        done;
   logic [1:0]  done_id;
   logic [3:0]  match_cnt;

   typedef struct {
      logic [1:0] id;
      logic [3:0] cnt;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_gnt_cyc = -1;
   bit   chk_gap = 1'b0;
   logic [1:0] m_ptr = 2'd0;
   exp_t sb[$];
   int   gnt_hist[$];

   always #5 clk = ~clk;

   seq_det_sched #(.NREQ(4), .WORD_W(8)) dut (
      .clk(clk), .rst_b(rst_b), .req(req), .data(data), .gnt(gnt), .busy(busy),
      .ser_x(ser_x), .done(done), .done_id(done_id), .match_cnt(match_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // count "110": a 0 after at least two consecutive 1s
   function automatic logic [3:0] model_cnt(input logic [7:0] w);
      int run = 0;
      logic [3:0] c = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w[i]) run++;
         else begin
            if (run >= 2 && c != 4'hF) c++;
            run = 0;
         end
      end
      return c;
   endfunction

   function automatic logic [1:0] model_win(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w = 2'd0;
      logic [1:0] ix;
      bit f = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
         ix = 2'(k);
`else
         ix = p + 2'(k);
`endif
         if (!f && r[ix]) begin
            w = ix;
            f = 1'b1;
         end
      end
      return w;
   endfunction

   task automatic tick();
      logic [3:0] rq;
      logic [1:0] w;
      exp_t e;
      rq = req;
      @(posedge clk);
      #1;
      cyc++;
      if (gnt !== 4'b0) begin
         chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
         w = model_win(rq, m_ptr);
         chk("gnt_winner", gnt, 4'b1 << w);
         if (chk_gap && last_gnt_cyc >= 0) chk("gnt_gap", cyc - last_gnt_cyc, 32'd11);
         last_gnt_cyc = cyc;
         gnt_hist.push_back(int'(w));
`ifndef SEQ_DET_SCHED_FIXED_PRIO_EN
         m_ptr = w + 2'd1;
`endif
         e.id  = w;
         e.cnt = model_cnt(data[32'(w) * 8 +: 8]);
         sb.push_back(e);
      end
      if (done === 1'b1) begin
         chk("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_id", done_id, e.id);
            chk("match_cnt", match_cnt, e.cnt);
         end
      end
   endtask

   task automatic run_job(input logic [1:0] id, input logic [7:0] w, input string tag);
      data = 32'h0;
      data[32'(id) * 8 +: 8] = w;
      req = 4'b1 << id;
      tick();
      chk({tag, "_gnt"}, gnt, 4'b1 << id);
      chk({tag, "_busy_gnt"}, busy, 1'b1);
      req = 4'b0;
      for (int b = 7; b >= 0; b--) begin
         tick();
         chk({tag, "_ser"}, ser_x, w[b]);
      end
      tick();
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_done"}, busy, 1'b1);
      tick();
      chk({tag, "_done_low"}, done, 1'b0);
      chk({tag, "_busy_low"}, busy, 1'b0);
      chk({tag, "_cnt_held"}, match_cnt, model_cnt(w));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 4'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_ser"}, ser_x, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_done_id"}, done_id, 2'd0);
      chk({tag, "_match"}, match_cnt, 4'd0);
   endtask

   initial begin
      int exp_order[5];
      repeat (3) tick();
      chk_zero("reset");
      rst_b = 1'b1;
      tick();

      // single job and pattern corner cases
      run_job(2'd1, 8'hDA, "single");
      chk("single_id", done_id, 2'd1);
      chk("single_cnt", match_cnt, 4'd2);
      run_job(2'd0, 8'hFF, "pat_ff");
      chk("pat_ff_cnt", match_cnt, 4'd0);
      run_job(2'd3, 8'h00, "pat_00");
      chk("pat_00_cnt", match_cnt, 4'd0);
      run_job(2'd2, 8'hC0, "pat_c0");
      chk("pat_c0_cnt", match_cnt, 4'd1);
      run_job(2'd0, 8'h6C, "pat_6c");
      chk("pat_6c_cnt", match_cnt, 4'd2);

      // fairness: all requesters held from reset
      rst_b = 1'b0;
      #1;
      m_ptr = 2'd0;
      sb.delete();
      gnt_hist.delete();
      last_gnt_cyc = -1;
      data = {8'h6C, 8'hC0, 8'hDA, 8'hFF};
      req = 4'b1111;
      tick();
      rst_b = 1'b1;
      chk_gap = 1'b1;
      repeat (55) tick();
      req = 4'b0;
      chk_gap = 1'b0;
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      chk("fair_count", gnt_hist.size(), 32'd5);
      for (int i = 0; i < 5 && i < gnt_hist.size(); i++) chk("fair_order", gnt_hist[i], exp_order[i]);

      // reset in the 4th shift cycle discards the job
      data = 32'h0;
      data[7:0] = 8'hFF;
      req = 4'b0001;
      tick();
      chk("midrst_gnt", gnt, 4'b0001);
      req = 4'b0;
      repeat (4) tick();
      chk("midrst_busy_before", busy, 1'b1);
      rst_b = 1'b0;
      #1;
      chk_zero("midrst");
      sb.delete();
      m_ptr = 2'd0;
      tick();
      rst_b = 1'b1;
      repeat (12) tick();
      chk("midrst_no_done", match_cnt, 4'd0);
      run_job(2'd2, 8'h6C, "post_rst");
      chk("post_rst_id", done_id, 2'd2);

      // requester 3 withdraws before it is served
      gnt_hist.delete();
      data = 32'h0;
      data[7:0] = 8'hC0;
      data[31:24] = 8'hFF;
      req = 4'b0001;
      tick();
      chk("drop_gnt0", gnt, 4'b0001);
      req = 4'b1000;
      repeat (9) tick();
      chk("drop_done0", done, 1'b1);
      tick();
      req = 4'b0;
      repeat (20) tick();
      chk("drop_grants", gnt_hist.size(), 32'd1);
      chk("drop_done_id", done_id, 2'd0);

`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
      gnt_hist.delete();
      data = 32'hA5C0_6CDA;
      req = 4'b1010;
      repeat (40) tick();
      req = 4'b0;
      repeat (12) tick();
      chk("fixed_count", 32'(gnt_hist.size() >= 3), 32'd1);
      for (int i = 0; i < gnt_hist.size(); i++) chk("fixed_winner", gnt_hist[i], 32'd1);
`endif

      repeat (3) tick();
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
